// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one dbus-style memory port among N requesters,
// one transaction in flight at a time, with a sticky watchdog for a stalled downstream.
module mem_port_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              req_valid,
  input  logic [N*64-1:0]           req_addr,
  input  logic [N*3-1:0]            req_size,
  input  logic [N*8-1:0]            req_strobe,
  input  logic [N*64-1:0]           req_data,
  output logic [N-1:0]              resp_addr_ok,
  output logic [N-1:0]              resp_data_ok,
  output logic [63:0]               resp_data,
  output logic                      mreq_valid,
  output logic [63:0]               mreq_addr,
  output logic [2:0]                mreq_size,
  output logic [7:0]                mreq_strobe,
  output logic [63:0]               mreq_data,
  input  logic                      mresp_addr_ok,
  input  logic                      mresp_data_ok,
  input  logic [63:0]               mresp_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id,
  output logic                      busy,
  output logic                      hang
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [GW-1:0] g;
  logic [GW-1:0] lg;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;
  logic          found;
  logic [CW-1:0] wd;

  logic [63:0] addr_arr   [N];
  logic [2:0]  size_arr   [N];
  logic [7:0]  strobe_arr [N];
  logic [63:0] data_arr   [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_arr[i]   = req_addr[i*64 +: 64];
      size_arr[i]   = req_size[i*3 +: 3];
      strobe_arr[i] = req_strobe[i*8 +: 8];
      data_arr[i]   = req_data[i*64 +: 64];
    end
  end

  // Search starts just after the last-served requester so every waiter gets a turn.
  always_comb begin
    pick  = lg;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = GW'((int'(lg) + i) % N);
      if (!found && req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      g     <= '0;
      lg    <= GW'(N - 1);
      wd    <= '0;
      hang  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            g     <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Always drop back to IDLE on completion: the finishing requester may
          // still show valid this cycle and must not be re-granted.
          if (mresp_data_ok) begin
            lg    <= g;
            state <= IDLE;
            wd    <= '0;
          end else if (wd != CW'(TIMEOUT)) begin
            wd <= wd + CW'(1);
          end
        end
      endcase
      if (wd == CW'(TIMEOUT)) hang <= 1'b1;
    end
  end

  assign busy     = (state == BUSY);
  assign grant_id = g;

  // Request fields are not registered; the requester holds them stable until data_ok.
  always_comb begin
    mreq_valid   = 1'b0;
    mreq_addr    = '0;
    mreq_size    = '0;
    mreq_strobe  = '0;
    mreq_data    = '0;
    resp_addr_ok = '0;
    resp_data_ok = '0;
    resp_data    = '0;
    if (state == BUSY) begin
      mreq_valid      = req_valid[g];
      mreq_addr       = addr_arr[g];
      mreq_size       = size_arr[g];
      mreq_strobe     = strobe_arr[g];
      mreq_data       = data_arr[g];
      resp_addr_ok[g] = mresp_addr_ok;
      resp_data_ok[g] = mresp_data_ok;
      resp_data       = mresp_data;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core-side memory port (dbus-style valid/addr_ok/data_ok protocol) among N requesters: instruction fetch, data access from the memory stage, and the page-table walker.
- Sits between the pipeline/MMU request sources and the external dbus.
- Round-robin, one outstanding transaction at a time; no transaction is split or reordered.
- Includes a watchdog that flags a stalled downstream.

Parameters:
- N, 3: number of requesters. Index 0 = fetch, 1 = memory stage, 2 = page-table walker.
- TIMEOUT, 1024: cycles in BUSY without mresp_data_ok before hang is raised.
- CW, 11: watchdog counter width. Must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  N  per-requester request valid
- req_addr  in  N*64  per-requester address; slice i = [64i+63:64i]
- req_size  in  N*3  per-requester msize encoding
- req_strobe  in  N*8  per-requester byte strobe; 0 = read
- req_data  in  N*64  per-requester write data
- resp_addr_ok  out  N  address accepted, routed to the granted requester only
- resp_data_ok  out  N  transaction done, routed to the granted requester only
- resp_data  out  64  read data, broadcast to all requesters (qualified by resp_data_ok)
- mreq_valid  out  1  downstream request valid
- mreq_addr  out  64  downstream address
- mreq_size  out  3  downstream size
- mreq_strobe  out  8  downstream strobe
- mreq_data  out  64  downstream write data
- mresp_addr_ok  in  1  downstream address accepted
- mresp_data_ok  in  1  downstream transaction done
- mresp_data  in  64  downstream read data
- grant_id  out  $clog2(N)  currently granted requester; valid while busy
- busy  out  1  transaction in flight
- hang  out  1  sticky watchdog flag

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- State: state ∈ {IDLE, BUSY}; grant register g; last-grant register lg; watchdog counter wd; hang flag.
- Reset values: state = IDLE, g = 0, lg = N-1, wd = 0, hang = 0.
- Reset values of outputs: all outputs 0.
- IDLE:
  - mreq_valid = 0; all resp_* = 0.
  - If any req_valid is set, pick the first set index searching lg+1, lg+2, … modulo N (wrap-around).
  - Load g, go to BUSY at the next edge.
  - No request: stay in IDLE.
- BUSY:
  - mreq_* = request fields of requester g; mreq_valid = req_valid[g].
  - resp_addr_ok[g] = mresp_addr_ok and resp_data_ok[g] = mresp_data_ok (combinational pass-through, zero latency).
  - All other resp bits = 0. resp_data = mresp_data.
- Completion: on the cycle mresp_data_ok = 1 in BUSY, set lg <= g, state <= IDLE, wd <= 0.
- Latency:
  - A request first seen at cycle t in IDLE appears downstream at t+1.
  - One mandatory IDLE bubble follows each completion. The completing requester's valid may still be high on the data_ok cycle, so re-arbitration on that cycle is forbidden.
- Requester rule: a requester holds valid and fields stable from assertion until its resp_data_ok. The arbiter does not register the request fields.
- Downstream rule: mreq_valid stays high after mresp_addr_ok until mresp_data_ok.
- addr_ok and data_ok in the same cycle is legal: the transaction completes that cycle.
- req_valid[g] dropping in BUSY before data_ok is a protocol violation. The arbiter stays in BUSY with mreq_valid = 0. The bench flags it with an assertion.
- Watchdog:
  - wd increments each BUSY cycle without data_ok and saturates at TIMEOUT.
  - When wd == TIMEOUT, hang <= 1. hang is sticky until reset.
  - No effect on arbitration.
- busy = (state == BUSY). grant_id = g.
- Reset mid-transaction: return to IDLE with lg = N-1 and drop the transaction without a response. The downstream is reset by the same signal.
- Fairness: with all N requesters continuously valid, each is served once per N transactions.

Test Plan:
- Single read: reset, then req_valid = 3'b001, addr 0x8000_0000, strobe 0. Downstream gives addr_ok at +1 and data_ok at +3 with 0xDEAD_BEEF → mreq_valid high exactly 3 cycles. resp_data_ok[0] pulses once with resp_data = 0xDEAD_BEEF. Then IDLE for 1 cycle.
- Round-robin: all three requesters valid continuously, downstream data_ok 1 cycle after grant → grant order 0, 1, 2, 0, 1, 2. Each transaction is separated by exactly 1 IDLE cycle.
- Wrap/priority: lg = 2 after serving requester 2, requesters 1 and 2 valid → requester 1 granted next.
- Write routing: requester 1 issues strobe 0xFF, data 0x1234 while requester 0 waits → mreq_strobe = 0xFF and mreq_data = 0x1234. resp_data_ok[0] stays 0 throughout.
- Same-cycle addr_ok and data_ok: requester 2 alone, downstream asserts both on the first BUSY cycle → completes in 1 BUSY cycle, busy deasserts next cycle.
- Watchdog and reset: TIMEOUT = 8, downstream never asserts data_ok → hang = 1 after 8 BUSY cycles and stays high. A reset pulse mid-transaction clears hang, busy and mreq_valid on the next cycle, and requester 0 wins the following arbitration.
